// File: rtl/rr_arbiter_seq.sv
// rr_arbiter_seq: registered round-robin arbiter with a rotating one-hot
// priority pointer, grant hold while the winner keeps requesting, and a
// hold limit that forces rotation when other channels are waiting.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no grant outstanding; arbitrate on any request
// S_GRANT | one channel granted; hold, hand over, or release to idle
//
// All outputs are registers; nothing in req reaches an output without
// passing through a flop.

module rr_arbiter_seq #(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 8,
   localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic          gnt_valid,
   output logic [IW-1:0] gnt_idx,
   output logic [N-1:0]  prio
);

   // hold counter must be able to represent MAX_HOLD itself (saturation value)
   localparam int HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
   localparam int HOLD_SAT = (MAX_HOLD > 0) ? MAX_HOLD : 0;

   localparam logic [N-1:0]  ONE_N   = {{(N-1){1'b0}}, 1'b1};
   localparam logic [HW-1:0] ONE_H   = {{(HW-1){1'b0}}, 1'b1};
   localparam logic [HW-1:0] LIM_H   = HW'(HOLD_LIM);
   localparam logic [HW-1:0] SAT_H   = HW'(HOLD_SAT);
   localparam logic          LIM_ON  = (MAX_HOLD != 0);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [N-1:0]    prio_q, prio_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [IW-1:0]   idx_q;
   logic            valid_q;

   logic [N-1:0]    others;
   logic [N-1:0]    rot_ptr;
   logic [N-1:0]    handover;
   logic            limit_hit;
   logic            winner_drop;
   logic            rel;

   // Lowest set bit of v at or above the pointer bit, wrapping to the
   // lowest set bit overall. p is one-hot, so (p - 1) masks everything
   // strictly below the pointer.
   function automatic logic [N-1:0] pick(input logic [N-1:0] v,
                                         input logic [N-1:0] p);
      logic [N-1:0] upper;
      logic [N-1:0] src;
      upper = v & ~(p - ONE_N);
      src   = (upper != '0) ? upper : v;
      return src & (~src + ONE_N);
   endfunction

   function automatic logic [IW-1:0] to_idx(input logic [N-1:0] oh);
      logic [IW-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (oh[i]) idx = idx | IW'(i);
      end
      return idx;
   endfunction

   function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
      return {v[N-2:0], v[N-1]};
   endfunction

   assign others      = req & ~gnt_q;
   assign rot_ptr     = rotl1(gnt_q);
   assign handover    = pick(others, rot_ptr);
   assign winner_drop = ((req & gnt_q) == '0);
   // The counter saturates at MAX_HOLD, so ">=" keeps the limit armed for a
   // winner that has been alone for a long time and is then joined by others.
   assign limit_hit   = LIM_ON && (hold_q >= LIM_H);
   assign rel         = winner_drop || (limit_hit && (others != '0));

   // Next-state, next-grant, pointer and hold-counter selection
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      prio_d  = prio_q;
      hold_d  = hold_q;
      unique case (state_q)
         S_IDLE: begin
            gnt_d = '0;
            if (req != '0) begin
               gnt_d   = pick(req, prio_q);
               hold_d  = '0;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (rel) begin
               // the old winner is excluded via 'others', even if still requesting
               prio_d = rot_ptr;
               hold_d = '0;
               if (handover != '0) begin
                  gnt_d = handover;
               end else begin
                  gnt_d   = '0;
                  state_d = S_IDLE;
               end
            end else if (hold_q < SAT_H) begin
               hold_d = hold_q + ONE_H;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; synchronous reset overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         prio_q  <= ONE_N;
         hold_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         prio_q  <= prio_d;
         hold_q  <= hold_d;
         idx_q   <= to_idx(gnt_d);
         valid_q <= (gnt_d != '0);
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = valid_q;
   assign gnt_idx   = idx_q;
   assign prio      = prio_q;

endmodule

// File: tb/tb_rr_arbiter_seq.sv
// Bench for rr_arbiter_seq (N=4, MAX_HOLD=4): directed vector table,
// reference-model scoreboard, random traffic and a starvation bound check.

module tb_rr_arbiter_seq;

   localparam int N  = 4;
   localparam int M  = 4;
   localparam int IW = 2;

   logic          clk;
   logic          rst;
   logic [N-1:0]  req;
   logic [N-1:0]  gnt;
   logic          gnt_valid;
   logic [IW-1:0] gnt_idx;
   logic [N-1:0]  prio;

   int n_cmp;
   int n_bad;

   rr_arbiter_seq #(.N(N), .MAX_HOLD(M)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx),
      .prio      (prio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          r;
      logic [N-1:0]  rq;
      logic [N-1:0]  eg;
      logic [N-1:0]  ep;
   } vec_t;

   typedef struct packed {
      logic [N-1:0]  g;
      logic          v;
      logic [IW-1:0] idx;
      logic [N-1:0]  p;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   // reference model state: granted index (-1 none), pointer index, hold count
   int m_g;
   int m_p;
   int m_h;

   function automatic int mpick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (p + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic void model_edge(input logic r, input logic [N-1:0] rq);
      logic [N-1:0] oth;
      logic         drop;
      logic         rel;
      if (r) begin
         m_g = -1; m_p = 0; m_h = 0;
      end else if (m_g < 0) begin
         if (rq != '0) begin
            m_g = mpick(rq, m_p);
            m_h = 0;
         end
      end else begin
         oth  = rq;
         oth[m_g] = 1'b0;
         drop = !rq[m_g];
         rel  = drop || (m_h >= M - 1 && oth != '0);
         if (rel) begin
            m_p = (m_g + 1) % N;
            m_g = mpick(oth, m_p);
            m_h = 0;
         end else if (m_h < M) begin
            m_h = m_h + 1;
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.g   = (m_g < 0) ? '0 : N'(1 << m_g);
      e.v   = (m_g >= 0);
      e.idx = (m_g < 0) ? '0 : IW'(m_g);
      e.p   = N'(1 << m_p);
      return e;
   endfunction

   function automatic logic [IW-1:0] oh_idx(input logic [N-1:0] oh);
      for (int i = 0; i < N; i++) if (oh[i]) return IW'(i);
      return '0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock: drive at negedge, push model expectation, check after posedge
   task automatic step(input logic r, input logic [N-1:0] rq);
      exp_t e;
      @(negedge clk);
      rst = r;
      req = rq;
      model_edge(r, rq);
      sb.push_back(model_out());
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("sb_gnt",   32'(gnt),       32'(e.g));
      chk("sb_valid", 32'(gnt_valid), 32'(e.v));
      chk("sb_idx",   32'(gnt_idx),   32'(e.idx));
      chk("sb_prio",  32'(prio),      32'(e.p));
      chk("onehot0",  32'($onehot0(gnt)), 32'd1);
      if (!r) chk("gnt_without_req", 32'(gnt & ~rq), 32'd0);
   endtask

   function automatic void add(input logic r, input logic [N-1:0] rq,
                               input logic [N-1:0] eg, input logic [N-1:0] ep);
      vecs.push_back('{r, rq, eg, ep});
   endfunction

   int wait_c[N];
   int wait_max[N];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      req   = '0;
      m_g = -1; m_p = 0; m_h = 0;

      // reset held with all requesting, then first grant
      add(1, 4'b1111, 4'b0000, 4'b0001);
      add(1, 4'b1111, 4'b0000, 4'b0001);
      add(0, 4'b1111, 4'b0001, 4'b0001);
      // grant ch1, then back-to-back handover to ch2 on drop
      add(1, 4'b0000, 4'b0000, 4'b0001);
      add(0, 4'b0110, 4'b0010, 4'b0001);
      add(0, 4'b0100, 4'b0100, 4'b0100);
      // release to idle leaves prio at ch3; wrap-around pick of ch0
      add(0, 4'b0000, 4'b0000, 4'b1000);
      add(0, 4'b0011, 4'b0001, 4'b1000);
      // all requesting: each grant lasts exactly MAX_HOLD cycles
      for (int i = 0; i < 3; i++) add(0, 4'b1111, 4'b0001, 4'b1000);
      for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b0010, 4'b0010);
      for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b0100, 4'b0100);
      for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b1000, 4'b1000);
      for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b0001, 4'b0001);
      add(0, 4'b1111, 4'b0010, 4'b0010);
      // reset pulse in the middle of a grant
      add(1, 4'b1111, 4'b0000, 4'b0001);
      add(0, 4'b1111, 4'b0001, 4'b0001);
      // lone requester keeps the grant indefinitely, prio frozen
      for (int i = 0; i < 20; i++) add(0, 4'b0100, 4'b0100, 4'b0010);
      // saturated hold: newcomer wins on the very next edge
      add(0, 4'b0101, 4'b0001, 4'b1000);
      add(0, 4'b0101, 4'b0001, 4'b1000);

      foreach (vecs[k]) begin
         step(vecs[k].r, vecs[k].rq);
         chk("tbl_gnt",  32'(gnt),       32'(vecs[k].eg));
         chk("tbl_prio", 32'(prio),      32'(vecs[k].ep));
         chk("tbl_idx",  32'(gnt_idx),   32'(oh_idx(vecs[k].eg)));
         chk("tbl_valid", 32'(gnt_valid), 32'(vecs[k].eg != '0));
      end

      // forced release while winner still requests: winner excluded from re-pick
      step(1, 4'b0000);
      step(0, 4'b0011);
      chk("force_first", 32'(gnt), 32'b0001);
      step(0, 4'b0011);
      step(0, 4'b0011);
      step(0, 4'b0011);
      step(0, 4'b0011);
      chk("force_handover", 32'(gnt), 32'b0010);
      chk("force_prio",     32'(prio), 32'b0010);

      // starvation bound with all channels requesting
      step(1, 4'b0000);
      for (int i = 0; i < N; i++) begin
         wait_c[i] = 0;
         wait_max[i] = 0;
      end
      for (int c = 0; c < 60; c++) begin
         step(0, 4'b1111);
         for (int i = 0; i < N; i++) begin
            if (gnt[i]) wait_c[i] = 0;
            else begin
               wait_c[i]++;
               if (wait_c[i] > wait_max[i]) wait_max[i] = wait_c[i];
            end
         end
      end
      for (int i = 0; i < N; i++)
         chk("starve_bound", 32'(wait_max[i] <= (N - 1) * M + 1), 32'd1);

      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
         step(($urandom_range(0, 39) == 0), N'($urandom_range(0, 15)));
      end

      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
